// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared register-file widths and writeback entry type
package cpu_defs_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_write_queue_if.sv
// rtl/wb_write_queue_if.sv - writeback push handshake into the write queue
interface wb_write_queue_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) ();

  logic              push_valid_i;
  logic              push_ready_o;
  logic [ADDR_W-1:0] push_addr_i;
  logic [DATA_W-1:0] push_data_i;

  modport master (
    output push_valid_i,
    output push_addr_i,
    output push_data_i,
    input  push_ready_o
  );

  modport slave (
    input  push_valid_i,
    input  push_addr_i,
    input  push_data_i,
    output push_ready_o
  );

endinterface

// File: rtl/wb_lookup_match.sv
// rtl/wb_lookup_match.sv - youngest-match search over the pending-write ring
module wb_lookup_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [DEPTH-1:0][ADDR_W-1:0] addr_i,
  input  logic [DEPTH-1:0][DATA_W-1:0] data_i,
  input  logic [PTR_W-1:0]             head_i,
  input  logic [ADDR_W-1:0]            key_i,
  output logic                         hit_o,
  output logic [DATA_W-1:0]            data_o
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PTR_W'(k);
      if (valid_i[idx] && (addr_i[idx] == key_i) && (key_i != '0)) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/wb_write_queue.sv
// rtl/wb_write_queue.sv - in-order writeback buffer draining into the register file
module wb_write_queue
  import cpu_defs_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  wb_write_queue_if.slave   push_if,
  input  logic              drainStall_i,
  output logic              writeEnable_o,
  output logic [ADDR_W-1:0] writeAddr_o,
  output logic [DATA_W-1:0] writeData_o,
  input  logic [ADDR_W-1:0] lookupAddr1_i,
  input  logic [ADDR_W-1:0] lookupAddr2_i,
  output logic              lookupHit1_o,
  output logic [DATA_W-1:0] lookupData1_o,
  output logic              lookupHit2_o,
  output logic [DATA_W-1:0] lookupData2_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o,
  output logic              full_o
);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0][ADDR_W-1:0] mem_addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] mem_data_q;

  logic push_fire, alloc, pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;

  // Ready comes from registered occupancy only, so a full queue refuses even when popping.
  assign push_if.push_ready_o = !full_o;
  assign push_fire = push_if.push_valid_i && push_if.push_ready_o;
  assign alloc     = push_fire && (push_if.push_addr_i != ADDR_W'(REG_ZERO));
  assign pop       = !empty_o && !drainStall_i;

  assign writeEnable_o = pop;
  assign writeAddr_o   = pop ? mem_addr_q[head_q] : '0;
  assign writeData_o   = pop ? mem_data_q[head_q] : '0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (pop) begin
      head_d          = head_q + 1'b1;
      valid_d[head_q] = 1'b0;
    end
    if (alloc) begin
      tail_d          = tail_q + 1'b1;
      valid_d[tail_q] = 1'b1;
    end
    unique case ({alloc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage is qualified by valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    if (alloc) begin
      mem_addr_q[tail_q] <= push_if.push_addr_i;
      mem_data_q[tail_q] <= push_if.push_data_i;
    end
  end

  wb_lookup_match #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .PTR_W (PTR_W)
  ) u_lookup1 (
    .valid_i(valid_q),
    .addr_i (mem_addr_q),
    .data_i (mem_data_q),
    .head_i (head_q),
    .key_i  (lookupAddr1_i),
    .hit_o  (lookupHit1_o),
    .data_o (lookupData1_o)
  );

  wb_lookup_match #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .PTR_W (PTR_W)
  ) u_lookup2 (
    .valid_i(valid_q),
    .addr_i (mem_addr_q),
    .data_i (mem_data_q),
    .head_i (head_q),
    .key_i  (lookupAddr2_i),
    .hit_o  (lookupHit2_o),
    .data_o (lookupData2_o)
  );

endmodule

// File: tb/tb_wb_write_queue.sv
// tb/tb_wb_write_queue.sv - scoreboard bench for the writeback write queue
module tb_wb_write_queue;
  import cpu_defs_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        drainStall_i = 1'b0;
  logic        writeEnable_o;
  logic [4:0]  writeAddr_o;
  logic [31:0] writeData_o;
  logic [4:0]  lookupAddr1_i = '0;
  logic [4:0]  lookupAddr2_i = '0;
  logic        lookupHit1_o, lookupHit2_o;
  logic [31:0] lookupData1_o, lookupData2_o;
  logic [2:0]  count_o;
  logic        empty_o, full_o;

  int n_checks = 0;
  int n_errors = 0;
  bit cnt_watch = 1'b0;
  wb_entry_t sb[$];

  wb_write_queue_if #(.ADDR_W(5), .DATA_W(32)) push_if ();

  wb_write_queue #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .push_if      (push_if),
    .drainStall_i (drainStall_i),
    .writeEnable_o(writeEnable_o),
    .writeAddr_o  (writeAddr_o),
    .writeData_o  (writeData_o),
    .lookupAddr1_i(lookupAddr1_i),
    .lookupAddr2_i(lookupAddr2_i),
    .lookupHit1_o (lookupHit1_o),
    .lookupData1_o(lookupData1_o),
    .lookupHit2_o (lookupHit2_o),
    .lookupData2_o(lookupData2_o),
    .count_o      (count_o),
    .empty_o      (empty_o),
    .full_o       (full_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every strobe must match the oldest write the bench has seen accepted.
  always @(negedge clk) begin
    if (rst && writeEnable_o) begin
      check("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        wb_entry_t e;
        e = sb.pop_front();
        check("write_addr", 32'(writeAddr_o), 32'(e.addr));
        check("write_data", writeData_o, e.data);
      end
    end
    if (rst && !writeEnable_o) begin
      check("idle_addr_zero", 32'(writeAddr_o), 32'd0);
      check("idle_data_zero", writeData_o, 32'd0);
    end
    if (cnt_watch) check("stream_count_le1", 32'(count_o <= 3'd1), 32'd1);
  end

  task automatic do_push(input logic [4:0] a, input logic [31:0] d, output bit acc);
    wb_entry_t e;
    @(posedge clk);
    #1;
    push_if.push_valid_i = 1'b1;
    push_if.push_addr_i  = a;
    push_if.push_data_i  = d;
    acc = push_if.push_ready_o;
    if (acc && a != 5'd0) begin
      e.addr = a;
      e.data = d;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      push_if.push_valid_i = 1'b0;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", 32'(push_if.push_ready_o), 32'd1);
    check("rst_we", 32'(writeEnable_o), 32'd0);
    check("rst_waddr", 32'(writeAddr_o), 32'd0);
    check("rst_wdata", writeData_o, 32'd0);
    check("rst_hit1", 32'(lookupHit1_o), 32'd0);
    check("rst_hit2", 32'(lookupHit2_o), 32'd0);
    check("rst_ldata1", lookupData1_o, 32'd0);
    check("rst_ldata2", lookupData2_o, 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_full", 32'(full_o), 32'd0);
  endtask

  initial begin
    bit acc;
    push_if.push_valid_i = 1'b0;
    push_if.push_addr_i  = '0;
    push_if.push_data_i  = '0;
    #12 rst = 1'b1;

    // Mid-cycle reset with buffered, stalled work and live lookup keys.
    drainStall_i = 1'b1;
    do_push(5'd3, 32'h33, acc);
    do_push(5'd9, 32'h99, acc);
    idle(1);
    lookupAddr1_i = 5'd3;
    lookupAddr2_i = 5'd9;
    #2 rst = 1'b0;
    #1 check_reset_outputs();
    sb.delete();
    drainStall_i = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(2);
    check("post_rst_ready", 32'(push_if.push_ready_o), 32'd1);
    check("post_rst_empty", 32'(empty_o), 32'd1);

    // Single write and first-write latency.
    do_push(5'd5, 32'hDEADBEEF, acc);
    check("single_acc", 32'(acc), 32'd1);
    idle(1);
    #3 check("single_we", 32'(writeEnable_o), 32'd1);
    check("single_waddr", 32'(writeAddr_o), 32'd5);
    check("single_wdata", writeData_o, 32'hDEADBEEF);
    idle(1);
    check("single_empty", 32'(empty_o), 32'd1);

    // Fill under stall, refuse the fifth push, drain in order.
    drainStall_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      do_push(5'(i), 32'(i * 32'h11), acc);
      check("fill_acc", 32'(acc), 32'd1);
    end
    do_push(5'd6, 32'h66, acc);
    check("fifth_refused", 32'(acc), 32'd0);
    check("fill_count", 32'(count_o), 32'd4);
    check("fill_full", 32'(full_o), 32'd1);
    idle(1);
    check("fill_count_hold", 32'(count_o), 32'd4);
    drainStall_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #3 check("drain_we", 32'(writeEnable_o), 32'd1);
      check("drain_order", 32'(writeAddr_o), 32'(i));
      idle(1);
    end
    check("drain_empty", 32'(empty_o), 32'd1);

    // Youngest-value forwarding, zero register never hits.
    drainStall_i = 1'b1;
    do_push(5'd7, 32'hA, acc);
    do_push(5'd7, 32'hB, acc);
    do_push(5'd8, 32'hC, acc);
    idle(1);
    lookupAddr1_i = 5'd7;
    lookupAddr2_i = 5'd0;
    #1 check("fwd_hit1", 32'(lookupHit1_o), 32'd1);
    check("fwd_data1", lookupData1_o, 32'hB);
    check("fwd_hit2_zero", 32'(lookupHit2_o), 32'd0);
    check("fwd_data2_zero", lookupData2_o, 32'd0);
    lookupAddr2_i = 5'd8;
    #1 check("fwd_hit2", 32'(lookupHit2_o), 32'd1);
    check("fwd_data2", lookupData2_o, 32'hC);
    lookupAddr2_i = 5'd12;
    #1 check("fwd_miss", 32'(lookupHit2_o), 32'd0);
    drainStall_i = 1'b0;
    idle(4);
    check("fwd_drained", 32'(empty_o), 32'd1);
    #1 check("fwd_gone", 32'(lookupHit1_o), 32'd0);

    // Zero-register push completes but allocates nothing.
    do_push(5'd0, 32'h1234, acc);
    check("zero_acc", 32'(acc), 32'd1);
    idle(1);
    check("zero_count", 32'(count_o), 32'd0);
    idle(2);

    // Back-to-back stream wraps the pointers twice with one write per cycle.
    cnt_watch = 1'b1;
    for (int i = 0; i < 10; i++) begin
      do_push(5'(10 + i), 32'hC0DE_0000 + 32'(i), acc);
      check("stream_acc", 32'(acc), 32'd1);
    end
    idle(2);
    cnt_watch = 1'b0;
    check("stream_done", 32'(sb.size()), 32'd0);

    // Reset while a write is pending discards it.
    drainStall_i = 1'b1;
    do_push(5'd21, 32'h2121, acc);
    do_push(5'd22, 32'h2222, acc);
    drainStall_i = 1'b0;
    #3 rst = 1'b0;
    #1 check("midrst_we", 32'(writeEnable_o), 32'd0);
    check("midrst_count", 32'(count_o), 32'd0);
    sb.delete();
    idle(2);
    rst = 1'b1;
    idle(4);
    check("midrst_empty", 32'(empty_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
